// File: rtl/mul_pkg.sv
// mul_pkg: shared widths and operand/result records for the multiplier issue logic (MUL_ISSUE_TAG_EN adds a tag to results)
package mul_pkg;
  localparam int OP_W = 128;
  localparam int RES_W = 256;
  localparam int TAG_W = 8;
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_t;
`ifdef MUL_ISSUE_TAG_EN
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [RES_W-1:0] prod;
  } res_t;
`else
  typedef struct packed {
    logic [RES_W-1:0] prod;
  } res_t;
`endif
endpackage

// File: rtl/mul_res_fifo.sv
// mul_res_fifo: show-ahead result FIFO; ports clk_i, rst_i, push_i/din_i, pop_i, dout_o (0 when empty), valid_o, cnt_o
module mul_res_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          valid_o,
  output logic [AW:0]   cnt_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop_i && cnt_q != '0;
    // a full FIFO may still take a push when the head leaves in the same cycle
    do_push = push_i && (cnt_q != (AW+1)'(DEPTH) || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din_i;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) mem_q <= mem_d;
  assign valid_o = cnt_q != '0;
  assign dout_o = valid_o ? mem_q[rd_q] : '0;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/mul_top.sv
// mul_top: pipelined unsigned 128x128 multiplier; ports clk_i, a_i, b_i, mul_o; product valid MUL_LAT-1 edges after operands change
module mul_top import mul_pkg::*; #(
  parameter int MUL_LAT = 2
) (
  input  logic             clk_i,
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  output logic [RES_W-1:0] mul_o
);
  logic [RES_W-1:0] prod;
  assign prod = RES_W'(a_i) * RES_W'(b_i);
  if (MUL_LAT == 1) begin : g_comb
    assign mul_o = prod;
  end else begin : g_pipe
    logic [RES_W-1:0] pipe_q [MUL_LAT-1];
    logic [RES_W-1:0] pipe_d [MUL_LAT-1];
    always_comb begin
      pipe_d[0] = prod;
      for (int i = 1; i < MUL_LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
    end
    always_ff @(posedge clk_i) pipe_q <= pipe_d;
    assign mul_o = pipe_q[MUL_LAT-2];
  end
endmodule

// File: rtl/mul_issue.sv
// mul_issue: issues operand pairs to an external multiplier and buffers ordered products; ports in_*, mul_a_o/mul_b_o/mul_i, res_*, busy_o; MUL_ISSUE_TAG_EN adds in_tag_i/res_tag_o
module mul_issue import mul_pkg::*; #(
  parameter int MUL_LAT = 2,
  parameter int RES_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OP_W-1:0]  in_a_i,
  input  logic [OP_W-1:0]  in_b_i,
`ifdef MUL_ISSUE_TAG_EN
  input  logic [TAG_W-1:0] in_tag_i,
  output logic [TAG_W-1:0] res_tag_o,
`endif
  output logic [OP_W-1:0]  mul_a_o,
  output logic [OP_W-1:0]  mul_b_o,
  input  logic [RES_W-1:0] mul_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [RES_W-1:0] res_o,
  output logic             busy_o
);
  localparam int CW = $clog2(RES_DEPTH) + 1;
  op_t op_q, op_d;
  logic [MUL_LAT-1:0] vld_q, vld_d;
  logic [CW-1:0] infl_q, infl_d, fifo_cnt;
  logic acc, push;
  res_t fifo_din, fifo_dout;
  always_comb begin
    acc = in_valid_i && in_ready_o;
    push = vld_q[MUL_LAT-1];
    op_d = acc ? op_t'{a: in_a_i, b: in_b_i} : op_q;
    vld_d = (vld_q << 1) | MUL_LAT'(acc);
    infl_d = infl_q + CW'(acc) - CW'(push);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q <= '0;
      vld_q <= '0;
      infl_q <= '0;
    end else begin
      op_q <= op_d;
      vld_q <= vld_d;
      infl_q <= infl_d;
    end
  end
`ifdef MUL_ISSUE_TAG_EN
  logic [TAG_W-1:0] tag_q [MUL_LAT];
  logic [TAG_W-1:0] tag_d [MUL_LAT];
  // tags shift unconditionally so they stay aligned with the valid bits
  always_comb begin
    tag_d[0] = in_tag_i;
    for (int i = 1; i < MUL_LAT; i++) tag_d[i] = tag_q[i-1];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) tag_q <= '{default: '0};
    else tag_q <= tag_d;
  end
  always_comb begin
    fifo_din = '0;
    fifo_din.prod = mul_i;
    fifo_din.tag = tag_q[MUL_LAT-1];
  end
  assign res_tag_o = fifo_dout.tag;
`else
  always_comb begin
    fifo_din = '0;
    fifo_din.prod = mul_i;
  end
`endif
  mul_res_fifo #(.W($bits(res_t)), .DEPTH(RES_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (res_ready_i),
    .dout_o  (fifo_dout),
    .valid_o (res_valid_o),
    .cnt_o   (fifo_cnt)
  );
  // credit check counts in-flight work too, so the FIFO can never overflow
  assign in_ready_o = (32'(infl_q) + 32'(fifo_cnt)) < 32'(RES_DEPTH);
  assign mul_a_o = op_q.a;
  assign mul_b_o = op_q.b;
  assign res_o = fifo_dout.prod;
  assign busy_o = infl_q != '0 || fifo_cnt != '0;
endmodule

// File: tb/tb_mul_issue.sv
// tb_mul_issue: self-checking bench for mul_issue with a matched mul_top
module tb_mul_issue;
  localparam int LAT = 2;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, in_valid = 0, res_ready = 0;
  logic [127:0] in_a = '0, in_b = '0;
  logic in_ready, res_valid, busy;
  logic [127:0] mul_a, mul_b;
  logic [255:0] mul_p, res;
`ifdef MUL_ISSUE_TAG_EN
  logic [7:0] in_tag = '0, res_tag;
`endif
  int n_tests = 0, n_fail = 0;
  logic [127:0] pa [16];
  logic [127:0] pb [16];
  int first_c, last_c, acc_cnt;
  always #5 clk = ~clk;
  mul_top #(.MUL_LAT(LAT)) u_mul (.clk_i(clk), .a_i(mul_a), .b_i(mul_b), .mul_o(mul_p));
  mul_issue #(.MUL_LAT(LAT), .RES_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b),
`ifdef MUL_ISSUE_TAG_EN
    .in_tag_i(in_tag), .res_tag_o(res_tag),
`endif
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_i(mul_p),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_o(res), .busy_o(busy)
  );
  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [255:0] exp;
  } vec_t;
  vec_t tbl [6];
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic one(input logic [127:0] a, input logic [127:0] b, input logic [255:0] exp);
    in_a = a;
    in_b = b;
`ifdef MUL_ISSUE_TAG_EN
    in_tag = 8'ha5;
`endif
    in_valid = 1;
    chk("ready_idle", 256'(in_ready), 256'd1);
    tick();
    in_valid = 0;
    chk("mul_a_reg", 256'(mul_a), 256'(a));
    chk("valid_k", 256'(res_valid), 256'd0);
    tick();
    chk("valid_k1", 256'(res_valid), 256'd0);
    tick();
    chk("valid_k2", 256'(res_valid), 256'd1);
    chk("product", res, exp);
`ifdef MUL_ISSUE_TAG_EN
    chk("tag_single", 256'(res_tag), 256'h a5);
`endif
    tick();
    chk("hold_no_ready", res, exp);
    res_ready = 1;
    tick();
    res_ready = 0;
    chk("busy_after", 256'(busy), 256'd0);
    chk("valid_after", 256'(res_valid), 256'd0);
  endtask
  // streams n pairs from pa/pb; res_ready held low for hold_low cycles
  task automatic run(input int n, input int hold_low, input int max_cyc);
    int ai = 0, ri = 0;
    logic acc, pop;
    logic [255:0] exp;
    for (int c = 0; c < max_cyc && ri < n; c++) begin
      if (c == hold_low && hold_low > 0) begin
        chk("accepted_while_stalled", 256'(ai), 256'(DEPTH));
        chk("ready_low_full", 256'(in_ready), 256'd0);
      end
      res_ready = c >= hold_low;
      in_valid = ai < n;
      in_a = pa[ai % 16];
      in_b = pb[ai % 16];
`ifdef MUL_ISSUE_TAG_EN
      in_tag = 8'(ai + 1);
`endif
      acc = in_valid && in_ready;
      pop = res_valid && res_ready;
      if (pop) begin
        exp = {128'h0, pa[ri]} * {128'h0, pb[ri]};
        chk($sformatf("stream_res%0d", ri), res, exp);
`ifdef MUL_ISSUE_TAG_EN
        chk($sformatf("stream_tag%0d", ri), 256'(res_tag), 256'(ri + 1));
`endif
        if (ri == 0) first_c = c;
        last_c = c;
        ri++;
      end
      tick();
      if (acc) ai++;
    end
    in_valid = 0;
    res_ready = 0;
    chk("stream_count", 256'(ri), 256'(n));
  endtask
  initial begin
    int seen;
    tbl[0] = '{{128{1'b1}}, {128{1'b1}}, {128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe, 128'h1}};
    tbl[1] = '{128'd2, 128'd1, 256'd2};
    tbl[2] = '{{128{1'b1}}, 128'd0, 256'd0};
    tbl[3] = '{128'd3, 128'd5, 256'd15};
    tbl[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd2, {128'h1, 128'h0}};
    tbl[5] = '{128'h1_0000_0000_0000_0000, 128'h1_0000_0000_0000_0001, {128'h1, 128'h1_0000_0000_0000_0000}};
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_ready", 256'(in_ready), 256'd1);
    chk("rst_valid", 256'(res_valid), 256'd0);
    chk("rst_res", res, 256'd0);
    chk("rst_mul_a", 256'(mul_a), 256'd0);
    chk("rst_mul_b", 256'(mul_b), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
`ifdef MUL_ISSUE_TAG_EN
    chk("rst_tag", 256'(res_tag), 256'd0);
`endif
    for (int i = 0; i < 6; i++) one(tbl[i].a, tbl[i].b, tbl[i].exp);
    for (int i = 0; i < 6; i++) begin
      pa[i] = 128'(i + 3);
      pb[i] = 128'(i + 7);
    end
    run(6, 10, 60);
    for (int i = 0; i < 10; i++) begin
      pa[i] = {128{1'b1}} + 128'(i);
      pb[i] = 128'(i);
    end
    run(10, 0, 60);
    chk("consecutive", 256'(last_c - first_c), 256'd9);
    pa[0] = 128'd11;
    pb[0] = 128'd13;
    in_a = pa[0];
    in_b = pb[0];
    in_valid = 1;
    acc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (in_ready) acc_cnt++;
      tick();
    end
    in_valid = 0;
    chk("pre_rst_accepts", 256'(acc_cnt), 256'd3);
    chk("pre_rst_busy", 256'(busy), 256'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("post_rst_busy", 256'(busy), 256'd0);
    chk("post_rst_ready", 256'(in_ready), 256'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid) seen++;
      tick();
    end
    chk("post_rst_no_valid", 256'(seen), 256'd0);
    one(128'd3, 128'd5, 256'd15);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
